rx_port128: RTL and testbench

Scatter-gather element front end of the RX port. It collects the 32-bit words of a scatter-gather list as they arrive from the completion engine, in bursts of variable width. Complete bus-width lines are stored in an internal FIFO. Elements (64-bit address, 32-bit length) are presented one at a time to the downstream RX read-request logic. Main-data, channel and TXN handling live in sibling blocks.

---
 rtl/rx_port128.sv | 248 ++++++++++++++++++++++++
 tb/tb_rx_port128.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_port128.sv
// rx_port128: scatter-gather element front end of the RX port.
// Packs variable-width bursts of 32-bit SG words into bus-width lines and
// queues them in a line FIFO. A reader presents the 4-word elements
// (64-bit address, 32-bit length, reserved word) one at a time.
//
// Ports:
//   CLK            rising-edge clock
//   RST            asynchronous active-low reset
//   SG_RX_DATA     incoming words, word i on bits [32i+31:32i]
//   SG_RX_DATA_EN  number of valid words in the low lanes (saturates at W)
//   SG_RX_DONE     list complete: flush the partial line (zero padded)
//   SG_RX_ERR      list aborted: discard the partial line and this beat
//   SG_ELEM_ADDR   current element address (registered)
//   SG_ELEM_LEN    current element length (registered)
//   SG_ELEM_RDY    element valid (registered)
//   SG_ELEM_REN    consume the current element
module rx_port128 #(
  parameter int unsigned C_DATA_WIDTH      = 256,
  parameter int unsigned C_SG_FIFO_DEPTH   = 1024,
  parameter int unsigned C_DATA_WORD_WIDTH = $clog2((C_DATA_WIDTH / 32) + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [C_DATA_WIDTH-1:0]      SG_RX_DATA,
  input  logic [C_DATA_WORD_WIDTH-1:0] SG_RX_DATA_EN,
  input  logic                         SG_RX_DONE,
  input  logic                         SG_RX_ERR,
  output logic [63:0]                  SG_ELEM_ADDR,
  output logic [31:0]                  SG_ELEM_LEN,
  output logic                         SG_ELEM_RDY,
  input  logic                         SG_ELEM_REN
);

  localparam int unsigned W  = C_DATA_WIDTH / 32;
  localparam int unsigned E  = W / 4;
  localparam int unsigned D  = C_SG_FIFO_DEPTH / W;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned SW = $clog2(2 * W);
  localparam int unsigned NW = $clog2(E + 1);
  localparam int unsigned KW = (E > 1) ? $clog2(E) : 1;
  localparam int unsigned LW = C_DATA_WIDTH + NW;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_EMIT = 1'b1;

  // ---------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------
  logic [W-1:0][31:0]   r_stage;
  logic [CW-1:0]        r_cnt;
  logic [2*W-1:0][31:0] w_comb;
  logic [SW-1:0]        w_en;
  logic [SW-1:0]        w_sum;
  logic [SW-1:0]        w_rem;
  logic [W-1:0][31:0]   w_rem_line;
  logic [W-1:0][31:0]   w_stage_d;
  logic [CW-1:0]        w_cnt_d;
  logic                 w_prod_a;
  logic                 w_prod_b;
  logic [NW-1:0]        w_nelem_b;

  always_comb begin
    w_en  = (SW'(SG_RX_DATA_EN) > SW'(W)) ? SW'(W) : SW'(SG_RX_DATA_EN);
    w_sum = SW'(r_cnt) + w_en;
    // Staged words first, then the new lanes appended at position cnt.
    w_comb = '0;
    for (int i = 0; i < W; i++) begin
      if (CW'(i) < r_cnt) w_comb[i] = r_stage[i];
    end
    for (int j = 0; j < W; j++) begin
      if (SW'(j) < w_en) w_comb[SW'(r_cnt) + SW'(j)] = SG_RX_DATA[j*32 +: 32];
    end
    if (w_sum >= SW'(W)) begin
      w_rem      = w_sum - SW'(W);
      w_rem_line = w_comb[2*W-1:W];
    end else begin
      w_rem      = w_sum;
      w_rem_line = w_comb[W-1:0];
    end
    w_prod_a  = !SG_RX_ERR && (w_sum >= SW'(W));
    w_prod_b  = !SG_RX_ERR && SG_RX_DONE && (w_rem != '0);
    w_nelem_b = NW'((w_rem + SW'(3)) >> 2);
    w_stage_d = w_rem_line;
    w_cnt_d   = (SG_RX_ERR || SG_RX_DONE) ? '0 : CW'(w_rem);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stage <= '0;
      r_cnt   <= '0;
    end else begin
      r_stage <= w_stage_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Two-entry pending queue in front of the FIFO. A DONE beat can finish
  // a full line and a flushed remainder in the same cycle. The second
  // slot only fills while cnt is 0, and from cnt 0 a beat yields at most
  // one line, so two slots never overflow.
  // ---------------------------------------------------------------------
  logic [LW-1:0] r_p0, r_p1;
  logic          r_p0_vld, r_p1_vld;
  logic [LW-1:0] w_new0, w_new1;
  logic          w_new0_v, w_new1_v;
  logic [LW-1:0] w_p0_d, w_p1_d;
  logic          w_p0_vld_d, w_p1_vld_d;

  always_comb begin
    w_new0   = w_prod_a ? {NW'(E), w_comb[W-1:0]} : {w_nelem_b, w_rem_line};
    w_new0_v = w_prod_a || w_prod_b;
    w_new1   = {w_nelem_b, w_rem_line};
    w_new1_v = w_prod_a && w_prod_b;
    // Slot 0 is offered to the FIFO every cycle it is valid.
    if (r_p1_vld) begin
      w_p0_d     = r_p1;
      w_p0_vld_d = 1'b1;
      w_p1_d     = w_new0;
      w_p1_vld_d = w_new0_v;
    end else begin
      w_p0_d     = w_new0;
      w_p0_vld_d = w_new0_v;
      w_p1_d     = w_new1;
      w_p1_vld_d = w_new1_v;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_p0     <= '0;
      r_p1     <= '0;
      r_p0_vld <= 1'b0;
      r_p1_vld <= 1'b0;
    end else begin
      r_p0     <= w_p0_d;
      r_p1     <= w_p1_d;
      r_p0_vld <= w_p0_vld_d;
      r_p1_vld <= w_p1_vld_d;
    end
  end

  // ---------------------------------------------------------------------
  // Line FIFO: extra pointer bit distinguishes full from empty.
  // ---------------------------------------------------------------------
  logic [LW-1:0] r_mem [D];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_push, w_pop;
  logic [LW-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // When full, a same-cycle pop frees the slot being written.
  assign w_push  = r_p0_vld && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_p0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Reader
  // ---------------------------------------------------------------------
  logic                r_state;
  logic [E-1:0][127:0] r_hold;
  logic [NW-1:0]       r_nelem;
  logic [KW-1:0]       r_k;
  logic                w_state_d;
  logic [E-1:0][127:0] w_hold_d;
  logic [NW-1:0]       w_nelem_d;
  logic [KW-1:0]       w_k_d;
  logic [NW-1:0]       w_k1;
  logic [127:0]        w_elem;
  logic [63:0]         r_addr;
  logic [31:0]         r_len;

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    w_nelem_d = r_nelem;
    w_k_d     = r_k;
    w_pop     = 1'b0;
    w_k1      = NW'(r_k) + NW'(1);
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_hold_d  = w_head[C_DATA_WIDTH-1:0];
          w_nelem_d = w_head[LW-1:C_DATA_WIDTH];
          w_k_d     = '0;
          w_state_d = S_EMIT;
        end
      end
      default: begin
        if (SG_ELEM_REN) begin
          if (w_k1 < r_nelem) begin
            w_k_d = KW'(w_k1);
          end else if (!w_empty) begin
            // Reload straight from the FIFO so lines stream without a bubble.
            w_pop     = 1'b1;
            w_hold_d  = w_head[C_DATA_WIDTH-1:0];
            w_nelem_d = w_head[LW-1:C_DATA_WIDTH];
            w_k_d     = '0;
          end else begin
            w_state_d = S_IDLE;
          end
        end
      end
    endcase
    w_elem = w_hold_d[w_k_d];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_nelem <= '0;
      r_k     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_d;
      r_hold  <= w_hold_d;
      r_nelem <= w_nelem_d;
      r_k     <= w_k_d;
      if (w_state_d == S_EMIT) begin
        r_addr <= w_elem[63:0];
        r_len  <= w_elem[95:64];
      end
    end
  end

  assign SG_ELEM_ADDR = r_addr;
  assign SG_ELEM_LEN  = r_len;
  assign SG_ELEM_RDY  = (r_state == S_EMIT);

endmodule

// File: tb/tb_rx_port128.sv
module tb_rx_port128;
  localparam int unsigned DW    = 256;
  localparam int unsigned W     = DW / 32;
  localparam int unsigned E     = W / 4;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned D     = DEPTH / W;
  localparam int unsigned EW    = $clog2(W + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] SG_RX_DATA = '0;
  logic [EW-1:0] SG_RX_DATA_EN = '0;
  logic          SG_RX_DONE = 1'b0;
  logic          SG_RX_ERR = 1'b0;
  logic [63:0]   SG_ELEM_ADDR;
  logic [31:0]   SG_ELEM_LEN;
  logic          SG_ELEM_RDY;
  logic          SG_ELEM_REN = 1'b0;

  rx_port128 #(
    .C_DATA_WIDTH     (DW),
    .C_SG_FIFO_DEPTH  (DEPTH),
    .C_DATA_WORD_WIDTH(EW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SG_RX_DATA   (SG_RX_DATA),
    .SG_RX_DATA_EN(SG_RX_DATA_EN),
    .SG_RX_DONE   (SG_RX_DONE),
    .SG_RX_ERR    (SG_RX_ERR),
    .SG_ELEM_ADDR (SG_ELEM_ADDR),
    .SG_ELEM_LEN  (SG_ELEM_LEN),
    .SG_ELEM_RDY  (SG_ELEM_RDY),
    .SG_ELEM_REN  (SG_ELEM_REN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [95:0] exp_q[$];  // {addr, len}
  logic [31:0] mq[$];     // model of staged words
  logic [31:0] bw[W];

  // Drives one beat from bw[] and updates the reference packer model.
  task automatic beat(input int en, input bit done, input bit err);
    for (int j = 0; j < W; j++) SG_RX_DATA[j*32 +: 32] = bw[j];
    SG_RX_DATA_EN = EW'(en);
    SG_RX_DONE    = done;
    SG_RX_ERR     = err;
    if (err) begin
      mq.delete();
    end else begin
      for (int j = 0; j < en; j++) mq.push_back(bw[j]);
      while (mq.size() >= W) begin
        for (int e = 0; e < E; e++) exp_q.push_back({mq[4*e+1], mq[4*e], mq[4*e+2]});
        repeat (W) void'(mq.pop_front());
      end
      if (done && mq.size() > 0) begin
        while (mq.size() % 4 != 0) mq.push_back(32'h0);
        while (mq.size() > 0) begin
          exp_q.push_back({mq[1], mq[0], mq[2]});
          repeat (4) void'(mq.pop_front());
        end
      end
    end
    @(negedge CLK);
    SG_RX_DATA_EN = '0;
    SG_RX_DONE    = 1'b0;
    SG_RX_ERR     = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (SG_ELEM_RDY !== 1'b0 || SG_ELEM_ADDR !== 64'h0 || SG_ELEM_LEN !== 32'h0) begin
      failures++;
      $display("FAIL reset: rdy=%b addr=%h len=%h expected 0/0/0",
               SG_ELEM_RDY, SG_ELEM_ADDR, SG_ELEM_LEN);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_full_beat();
    int lat;
    bw = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h11, 32'h21, 32'h31, 32'h41};
    beat(8, 1'b0, 1'b0);
    lat = 1;
    while (SG_ELEM_RDY !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL full_beat_latency: got %0d cycles expected 3", lat);
    end
    checks++;
    if (SG_ELEM_ADDR !== 64'h00000020_00000010 || SG_ELEM_LEN !== 32'h30) begin
      failures++;
      $display("FAIL full_beat_first: addr=%h len=%h expected 0000002000000010/30",
               SG_ELEM_ADDR, SG_ELEM_LEN);
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL full_beat_elem: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        SG_ELEM_REN = 1'b1;
      end else SG_ELEM_REN = 1'b0;
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (exp_q.size() != 0 || SG_ELEM_RDY !== 1'b0) begin
      failures++;
      $display("FAIL full_beat_end: left=%0d rdy=%b expected 0/0", exp_q.size(), SG_ELEM_RDY);
    end
  endtask

  task automatic test_split_beats();
    int early = 0;
    bw = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    beat(3, 1'b0, 1'b0);
    bw[0] = 32'd4; bw[1] = 32'd5; bw[2] = 32'd6;
    beat(3, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (SG_ELEM_RDY) early++;
      @(negedge CLK);
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL split_early: rdy high %0d cycles expected 0", early);
    end
    bw[0] = 32'd7; bw[1] = 32'd8; bw[2] = 32'd0;
    beat(2, 1'b0, 1'b0);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL split_elem: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        SG_ELEM_REN = 1'b1;
      end else SG_ELEM_REN = 1'b0;
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (exp_q.size() != 0 || SG_ELEM_RDY !== 1'b0) begin
      failures++;
      $display("FAIL split_end: left=%0d rdy=%b expected 0/0", exp_q.size(), SG_ELEM_RDY);
    end
  endtask

  // DONE flush, then ERR abort; the trailing full beats prove cnt is back to 0.
  task automatic test_done_err();
    int early = 0;
    bw = '{32'hA0A0, 32'hB0B0, 32'hC0C0, 32'hD0D0, 32'h0, 32'h0, 32'h0, 32'h0};
    beat(4, 1'b1, 1'b0);
    for (int j = 0; j < W; j++) bw[j] = 32'h300 + j;
    beat(8, 1'b0, 1'b0);
    for (int j = 0; j < W; j++) bw[j] = 32'h400 + j;
    beat(5, 1'b0, 1'b0);
    beat(2, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) @(negedge CLK);
    for (int j = 0; j < W; j++) bw[j] = 32'h500 + j;
    beat(8, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 1 + 2 * E) begin
      failures++;
      $display("FAIL done_err_model: queued %0d expected %0d", exp_q.size(), 1 + 2 * E);
    end
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL done_err_elem: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        SG_ELEM_REN = 1'b1;
      end else SG_ELEM_REN = 1'b0;
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (SG_ELEM_RDY) early++;
      @(negedge CLK);
    end
    checks++;
    if (exp_q.size() != 0 || early != 0) begin
      failures++;
      $display("FAIL done_err_end: left=%0d extra_rdy=%0d expected 0/0", exp_q.size(), early);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last = -1;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < W; j++) bw[j] = 32'h1000 * (l + 1) + j;
      beat(8, 1'b0, 1'b0);
    end
    repeat (4) @(negedge CLK);
    SG_ELEM_REN = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        if (first < 0) first = c;
        last = c;
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_elem: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (exp_q.size() != 0 || last - first != 3 * E - 1 || SG_ELEM_RDY !== 1'b0) begin
      failures++;
      $display("FAIL b2b_span: left=%0d span=%0d rdy=%b expected 0/%0d/0",
               exp_q.size(), last - first, SG_ELEM_RDY, 3 * E - 1);
    end
  endtask

  task automatic test_overflow_reset();
    int extra = 0;
    // Park one line in the reader, then offer D+1 lines to the FIFO.
    for (int j = 0; j < W; j++) bw[j] = 32'h7000 + j;
    beat(8, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    for (int l = 0; l <= D; l++) begin
      for (int j = 0; j < W; j++) bw[j] = 32'h8000 + 32'h100 * l + j;
      beat(8, 1'b0, 1'b0);
    end
    repeat (E) void'(exp_q.pop_back());
    repeat (3) @(negedge CLK);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL ovf_elem: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        SG_ELEM_REN = 1'b1;
      end else SG_ELEM_REN = 1'b0;
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (exp_q.size() != 0 || SG_ELEM_RDY !== 1'b0) begin
      failures++;
      $display("FAIL ovf_end: left=%0d rdy=%b expected 0/0", exp_q.size(), SG_ELEM_RDY);
    end
    // Reset mid-stream: two lines queued plus a partial line staged.
    for (int l = 0; l < 2; l++) begin
      for (int j = 0; j < W; j++) bw[j] = 32'h9000 + 32'h100 * l + j;
      beat(8, 1'b0, 1'b0);
    end
    beat(3, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++;
    if (SG_ELEM_RDY !== 1'b0 || SG_ELEM_ADDR !== 64'h0 || SG_ELEM_LEN !== 32'h0) begin
      failures++;
      $display("FAIL rst_async: rdy=%b addr=%h len=%h expected 0/0/0",
               SG_ELEM_RDY, SG_ELEM_ADDR, SG_ELEM_LEN);
    end
    exp_q.delete();
    mq.delete();
    @(negedge CLK);
    RST = 1'b1;
    SG_ELEM_REN = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (SG_ELEM_RDY) extra++;
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL rst_flush: rdy high %0d cycles expected 0", extra);
    end
    for (int j = 0; j < W; j++) bw[j] = 32'hA000 + j;
    beat(8, 1'b0, 1'b0);
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (SG_ELEM_RDY) begin
        checks++;
        if ({SG_ELEM_ADDR, SG_ELEM_LEN} !== exp_q[0]) begin
          failures++;
          $display("FAIL rst_after: got %h expected %h", {SG_ELEM_ADDR, SG_ELEM_LEN}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        SG_ELEM_REN = 1'b1;
      end else SG_ELEM_REN = 1'b0;
      @(negedge CLK);
    end
    SG_ELEM_REN = 1'b0;
    checks++;
    if (exp_q.size() != 0 || SG_ELEM_RDY !== 1'b0) begin
      failures++;
      $display("FAIL rst_end: left=%0d rdy=%b expected 0/0", exp_q.size(), SG_ELEM_RDY);
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_split_beats();
    test_done_err();
    test_back_to_back();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
